// File: rtl/im_loader_pkg.sv
// im_loader_pkg: constants and helpers shared by the instruction-memory
// loader, the instruction memory and instruction fetch.
//   IM_BASE_ADDR : byte address of the first instruction word (text base)
//   IM_DEPTH     : instruction memory capacity in words
//   IM_CNT_W     : width of a word counter able to hold IM_DEPTH
//   state_t      : loader state encoding
//   word_addr    : PC-form byte address of a word index
package im_loader_pkg;

  localparam logic [31:0] IM_BASE_ADDR = 32'h0000_3000;
  localparam int unsigned IM_DEPTH     = 4096;
  localparam int unsigned IM_CNT_W     = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // base + 4*index, 32-bit unsigned.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] index);
    return base + {index[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/im_loader_if.sv
// im_loader_if: byte-stream valid/ready channel carrying a program image.
//   data  : program byte
//   valid : data is valid
//   last  : final byte of the program, qualified by valid
//   ready : sink accepts a byte this cycle
// master = byte source, slave = loader.
interface im_loader_if;

  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/im_loader_byte_packer.sv
// im_loader_byte_packer: assembles big-endian bytes into 32-bit words.
//   clk, reset_n : clock, asynchronous active-low reset
//   accept       : a byte transfers on this edge
//   last         : the accepted byte is the final one of the program
//   data         : the byte
//   word_ready   : this accept completes a word (4th byte or last)
//   word         : packed word including the current byte, low bytes zero
module im_loader_byte_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        accept,
  input  logic        last,
  input  logic [7:0]  data,
  output logic        word_ready,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [31:0] sr;
  logic [31:0] lane;

  // sr only ever holds bytes already placed in their final lane, with the
  // not-yet-received lanes zero, so OR-ing in the current byte both packs
  // and zero-pads a short final word.
  always_comb begin
    lane = '0;
    case (idx)
      2'd0:    lane = {data, 24'h0};
      2'd1:    lane = {8'h0, data, 16'h0};
      2'd2:    lane = {16'h0, data, 8'h0};
      default: lane = {24'h0, data};
    endcase
    word       = sr | lane;
    word_ready = accept & (last | (idx == 2'd3));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx <= '0;
      sr  <= '0;
    end else if (accept) begin
      if (word_ready) begin
        idx <= '0;
        sr  <= '0;
      end else begin
        idx <= idx + 2'd1;
        sr  <= word;
      end
    end
  end

endmodule

// File: rtl/im_loader.sv
// im_loader: writes a program received as a big-endian byte stream into the
// instruction memory, holding the CPU stalled while loading.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : one-cycle pulse, begins a load (ignored while loading)
//   in_bus       : byte stream (data/valid/last in, ready out)
//   im_we        : one-cycle IM write strobe per word
//   im_addr      : byte address of the word, BASE_ADDR + 4*index
//   im_wdata     : instruction word
//   busy         : loading or final write pending (CPU stall)
//   done         : level, load completed
//   overflow     : sticky, more than DEPTH words were presented
//   word_count   : words written in the current or last load
module im_loader
  import im_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IM_BASE_ADDR,
  parameter int unsigned DEPTH     = IM_DEPTH,
  parameter int unsigned CNT_W     = IM_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  im_loader_if.slave       in_bus,
  output logic             im_we,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] word_count
);

  state_t      state;
  logic        ready_q;
  logic        finishing;
  logic        accept;
  logic        at_cap;
  logic        word_ready;
  logic [31:0] word;

  assign in_bus.ready = ready_q;
  assign accept       = in_bus.valid & ready_q;
  assign at_cap       = (word_count == CNT_W'(DEPTH));

  im_loader_byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .accept     (accept),
    .last       (in_bus.last),
    .data       (in_bus.data),
    .word_ready (word_ready),
    .word       (word)
  );

  // After the byte carrying last, LOAD lingers one cycle with ready low
  // ('finishing') so busy drops exactly as the final im_we pulse ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ready_q    <= 1'b0;
      finishing  <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      im_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_LOAD;
            ready_q    <= 1'b1;
            finishing  <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
          end
        end
        ST_LOAD: begin
          if (finishing) begin
            state     <= ST_DONE;
            finishing <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (accept) begin
            if (at_cap) begin
              overflow <= 1'b1;
            end else if (word_ready) begin
              im_we      <= 1'b1;
              im_wdata   <= word;
              im_addr    <= word_addr(BASE_ADDR, 32'(word_count));
              word_count <= word_count + CNT_W'(1);
            end
            if (in_bus.last) begin
              ready_q   <= 1'b0;
              finishing <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: self-checking bench for im_loader (DEPTH reduced to 4 so the
// overflow boundary is reachable). Expected IM writes are queued when a load
// is driven and popped by a monitor whenever im_we is seen.
module tb_im_loader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  typedef logic [0:19][7:0] bytes_t;

  typedef struct packed {
    bytes_t     b;
    logic [4:0] n;
    logic       gaps;
    logic [2:0] exp_cnt;
    logic       exp_ovf;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             im_we;
  logic [31:0]      im_addr;
  logic [31:0]      im_wdata;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [CNT_W-1:0] word_count;

  im_loader_if bus ();

  int unsigned compared = 0;
  int unsigned mismatched = 0;
  wr_t exp_q[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  im_loader #(
    .BASE_ADDR (32'h0000_3000),
    .DEPTH     (DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .in_bus     (bus),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Write monitor: every im_we cycle must match the head of the queue.
  always @(negedge clk) begin
    wr_t e;
    if (reset_n && im_we === 1'b1) begin
      check("busy_during_write", 32'(busy), 32'd1);
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                 im_addr, im_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", im_addr, e.addr);
        check("write_data", im_wdata, e.data);
      end
    end
  end

  // Reference: big-endian packing, zero padding, drop words past DEPTH.
  task automatic push_expected(input vec_t v);
    int unsigned nw;
    int unsigned idx;
    logic [31:0] d;
    logic [7:0]  by;
    nw = (32'(v.n) + 3) / 4;
    for (int unsigned w = 0; w < nw && w < DEPTH; w++) begin
      d = '0;
      for (int unsigned k = 0; k < 4; k++) begin
        idx = 4 * w + k;
        by  = (idx < 32'(v.n)) ? v.b[idx] : 8'h00;
        d   = {d[23:0], by};
      end
      exp_q.push_back('{addr: 32'h0000_3000 + 4 * w, data: d});
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_started();
    check("start_done_clr", 32'(done), 32'd0);
    check("start_ovf_clr", 32'(overflow), 32'd0);
    check("start_count_clr", 32'(word_count), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(bus.ready), 32'd1);
  endtask

  // Sends b[from..to-1]; returns #1 after the edge accepting the final byte.
  task automatic send_bytes(input bytes_t b, input int unsigned from, input int unsigned to,
                            input logic last, input logic gaps);
    int unsigned i;
    int unsigned cyc;
    logic rdy;
    i = from;
    cyc = 0;
    while (i < to && cyc < 300) begin
      @(negedge clk);
      bus.valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.data  = b[i];
      bus.last  = last && (i == to - 1);
      rdy = bus.ready;
      @(posedge clk);
      if (bus.valid && rdy) i++;
      cyc++;
    end
    #1;
    bus.valid = 1'b0;
    bus.last  = 1'b0;
    check("bytes_accepted", i, to);
  endtask

  task automatic wait_done(input logic [2:0] exp_cnt, input logic exp_ovf);
    int unsigned cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("done", 32'(done), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
    check("we_after", 32'(im_we), 32'd0);
    check("ready_after", 32'(bus.ready), 32'd0);
    check("word_count", 32'(word_count), 32'(exp_cnt));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    push_expected(v);
    do_start();
    check_started();
    send_bytes(v.b, 0, 32'(v.n), 1'b1, v.gaps);
    wait_done(v.exp_cnt, v.exp_ovf);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bytes_t bb;
    bus.valid = 1'b0;
    bus.last  = 1'b0;
    bus.data  = 8'h00;

    bb = {8'h34, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 96'h0};
    vecs[0] = '{b: bb, n: 5'd8, gaps: 1'b0, exp_cnt: 3'd2, exp_ovf: 1'b0};
    bb = {8'hAA, 8'hBB, 8'hCC, 136'h0};
    vecs[1] = '{b: bb, n: 5'd3, gaps: 1'b0, exp_cnt: 3'd1, exp_ovf: 1'b0};
    for (int i = 0; i < 20; i++) bb[i] = 8'(i * 37 + 5);
    vecs[2] = '{b: bb, n: 5'd12, gaps: 1'b1, exp_cnt: 3'd3, exp_ovf: 1'b0};
    for (int i = 0; i < 20; i++) bb[i] = 8'(i * 11 + 8'h81);
    vecs[3] = '{b: bb, n: 5'd20, gaps: 1'b0, exp_cnt: 3'd4, exp_ovf: 1'b1};
    bb = {8'h5A, 152'h0};
    vecs[4] = '{b: bb, n: 5'd1, gaps: 1'b0, exp_cnt: 3'd1, exp_ovf: 1'b0};
    for (int i = 0; i < 20; i++) bb[i] = 8'(255 - i * 13);
    vecs[5] = '{b: bb, n: 5'd16, gaps: 1'b1, exp_cnt: 3'd4, exp_ovf: 1'b0};
    vecs[6] = '{b: bb, n: 5'd17, gaps: 1'b0, exp_cnt: 3'd4, exp_ovf: 1'b1};

    #12;
    check("rst_we", 32'(im_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_addr", im_addr, 32'd0);
    check("rst_wdata", im_wdata, 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // start pulse in the middle of a load must not disturb it
    bb = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 96'h0};
    exp_q.push_back('{addr: 32'h0000_3000, data: 32'h1122_3344});
    exp_q.push_back('{addr: 32'h0000_3004, data: 32'h5566_7788});
    do_start();
    check_started();
    send_bytes(bb, 0, 6, 1'b0, 1'b0);
    do_start();
    check("mid_start_count", 32'(word_count), 32'd1);
    check("mid_start_busy", 32'(busy), 32'd1);
    send_bytes(bb, 6, 8, 1'b1, 1'b0);
    wait_done(3'd2, 1'b0);

    // reset while the write strobe is high; that write is abandoned
    bb = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 128'h0};
    do_start();
    check_started();
    send_bytes(bb, 0, 4, 1'b0, 1'b0);
    check("we_before_reset", 32'(im_we), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_we", 32'(im_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_count", 32'(word_count), 32'd0);
    check("midrst_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bb = {8'hCA, 8'hFE, 8'hBA, 8'hBE, 128'h0};
    run_vec('{b: bb, n: 5'd4, gaps: 1'b0, exp_cnt: 3'd1, exp_ovf: 1'b0});

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
